// File: rtl/cips_seq.sv
// cips_seq: single-cycle microsequencer with program counter, writable program
// memory, accumulator with carry, registered output port, conditional and
// unconditional jumps, halt/resume and a run-time program-load port.
// Optional feature: define CIPS_SINGLE_STEP_EN to execute only on edges where
// step=1 (otherwise step is ignored and one instruction executes per edge).
module cips_seq #(
    parameter int PC_W = 8,
    parameter int DATA_W = 5,
    localparam int INSTR_W = PC_W + 3
) (
    input  logic               clk,
    input  logic               R,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               run,
    input  logic               step,
    output logic [PC_W-1:0]    PC_out,
    output logic [INSTR_W-1:0] memory_out,
    output logic [PC_W-1:0]    adder_out,
    output logic [DATA_W-1:0]  Output,
    output logic               out_valid,
    output logic               halted
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_ADDI = 3'b010,
        OP_OUT  = 3'b011,
        OP_JMP  = 3'b100,
        OP_JZ   = 3'b101,
        OP_JC   = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [PC_W-1:0]     pc, pc_n, pc_inc;
    logic [DATA_W-1:0]   acc, acc_n;
    logic                c, c_n;
    logic [DATA_W-1:0]   out_r, out_n;
    logic                ov, ov_n;
    logic                exec_en;
    logic [INSTR_W-1:0]  mem [0:(1<<PC_W)-1];
    logic [INSTR_W-1:0]  instr;
    opcode_t             opcode;
    logic [PC_W-1:0]     operand;
    logic [DATA_W-1:0]   k;
    logic [DATA_W:0]     sum;

`ifdef CIPS_SINGLE_STEP_EN
    assign exec_en = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign exec_en = 1'b1;
`endif

    // Program memory: written through the load port, never cleared by reset
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign instr   = mem[pc];
    assign opcode  = opcode_t'(instr[INSTR_W-1:PC_W]);
    assign operand = instr[PC_W-1:0];
    assign k       = operand[DATA_W-1:0];
    assign pc_inc  = pc + PC_W'(1);
    assign sum     = {1'b0, acc} + {1'b0, k};

    // State and datapath registers
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state <= ST_RUN;
            pc    <= '0;
            acc   <= '0;
            c     <= 1'b0;
            out_r <= '0;
            ov    <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            acc   <= acc_n;
            c     <= c_n;
            out_r <= out_n;
            ov    <= ov_n;
        end
    end

    // Next-state decode: execute one instruction in RUN, wait for run in HALT
    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        c_n     = c;
        out_n   = out_r;
        ov_n    = 1'b0;
        case (state)
            ST_RUN: begin
                if (exec_en) begin
                    pc_n = pc_inc;
                    case (opcode)
                        OP_NOP: ;
                        OP_LDI: begin
                            acc_n = k;
                            c_n   = 1'b0;
                        end
                        OP_ADDI: {c_n, acc_n} = sum;
                        OP_OUT: begin
                            out_n = acc;
                            ov_n  = 1'b1;
                        end
                        OP_JMP: pc_n = operand;
                        OP_JZ: begin
                            if (acc == '0) pc_n = operand;
                        end
                        OP_JC: begin
                            if (c) pc_n = operand;
                        end
                        OP_HALT: begin
                            pc_n    = pc;
                            state_n = ST_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HALT: begin
                if (run) begin
                    pc_n    = pc_inc;
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign PC_out     = pc;
    assign memory_out = instr;
    assign adder_out  = pc_inc;
    assign Output     = out_r;
    assign out_valid  = ov;
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_cips_seq.sv
// tb_cips_seq: directed program tests for cips_seq, checked every cycle
// against an instruction-level model plus hand-computed literal expectations.
module tb_cips_seq;

    localparam int PC_W   = 8;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 1 << PC_W;
    localparam int DMOD   = 1 << DATA_W;

    logic        clk;
    logic        R;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [10:0] prog_data;
    logic        run;
    logic        step;
    logic [7:0]  PC_out;
    logic [10:0] memory_out;
    logic [7:0]  adder_out;
    logic [4:0]  Output;
    logic        out_valid;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 0;

    // Instruction-level model state
    int m_mem [DEPTH];
    int m_pc, m_acc, m_c, m_out, m_ov, m_halt;

    cips_seq #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .R(R), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .step(step), .PC_out(PC_out),
        .memory_out(memory_out), .adder_out(adder_out), .Output(Output),
        .out_valid(out_valid), .halted(halted)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ins(int op, int opd);
        logic [2:0] o;
        logic [7:0] d;
        o = 3'(op);
        d = 8'(opd);
        return {o, d};
    endfunction

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(int a, logic [10:0] d);
        prog_we   = 1;
        prog_addr = 8'(a);
        prog_data = d;
        tick(1);
        prog_we   = 0;
    endtask

    // Model memory updates after the executing read at the same edge
    always @(posedge clk) begin
        if (prog_we) m_mem[prog_addr] <= int'(prog_data);
    end

    // Model: one instruction per edge from the specification's rules
    always @(posedge clk or posedge R) begin
        int op, opd, k, s;
        bit go;
        if (R) begin
            m_pc = 0; m_acc = 0; m_c = 0; m_out = 0; m_ov = 0; m_halt = 0;
        end else begin
            op  = m_mem[m_pc] / DEPTH;
            opd = m_mem[m_pc] % DEPTH;
            k   = opd % DMOD;
`ifdef CIPS_SINGLE_STEP_EN
            go = step;
`else
            go = 1;
`endif
            m_ov = 0;
            if (m_halt != 0) begin
                if (run) begin
                    m_pc = (m_pc + 1) % DEPTH;
                    m_halt = 0;
                end
            end else if (go) begin
                if (op == 7) begin
                    m_halt = 1;
                end else begin
                    m_pc = (m_pc + 1) % DEPTH;
                    if (op == 1) begin m_acc = k; m_c = 0; end
                    if (op == 2) begin
                        s = m_acc + k;
                        m_c = (s >= DMOD) ? 1 : 0;
                        m_acc = s % DMOD;
                    end
                    if (op == 3) begin m_out = m_acc; m_ov = 1; end
                    if (op == 4) m_pc = opd;
                    if (op == 5 && m_acc == 0) m_pc = opd;
                    if (op == 6 && m_c == 1) m_pc = opd;
                end
            end
        end
    end

    // Per-cycle comparison of every observable output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", int'(PC_out), m_pc);
            chk("mem_out", int'(memory_out), m_mem[m_pc]);
            chk("adder", int'(adder_out), (m_pc + 1) % DEPTH);
            chk("output", int'(Output), m_out);
            chk("out_valid", int'(out_valid), m_ov);
            chk("halted", int'(halted), m_halt);
        end
    end

    initial begin
        R = 1; prog_we = 0; prog_addr = 0; prog_data = 0; run = 0; step = 1;
        tick(1);
        for (int a = 0; a < DEPTH; a++) wr(a, 11'd0);
        cmp_en = 1;

        chk("rst_pc", int'(PC_out), 0);
        chk("rst_output", int'(Output), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_halted", int'(halted), 0);

        // LDI 3; ADDI 4; OUT; HALT
        wr(0, ins(1, 3)); wr(1, ins(2, 4)); wr(2, ins(3, 0)); wr(3, ins(7, 0));
        R = 0;
        tick(3);
        chk("t1_output", int'(Output), 7);
        chk("t1_valid_hi", int'(out_valid), 1);
        tick(1);
        chk("t1_valid_lo", int'(out_valid), 0);
        chk("t1_halted", int'(halted), 1);
        chk("t1_pc_halt", int'(PC_out), 3);
        tick(2);
        chk("t1_pc_hold", int'(PC_out), 3);
        run = 1;
        tick(1);
        run = 0;
        chk("t1_pc_run", int'(PC_out), 4);
        chk("t1_unhalt", int'(halted), 0);
        tick(2);

        // Carry: LDI 30; ADDI 5; JC 10; mem[10]=OUT
        R = 1;
        wr(0, ins(1, 30)); wr(1, ins(2, 5)); wr(2, ins(6, 10));
        wr(10, ins(3, 0)); wr(11, ins(7, 0));
        R = 0;
        tick(2);
        chk("t2_pc2", int'(PC_out), 2);
        tick(1);
        chk("t2_jc_taken", int'(PC_out), 10);
        tick(1);
        chk("t2_output", int'(Output), 3);
        chk("t2_valid", int'(out_valid), 1);
        tick(2);

        // JZ taken
        R = 1;
        wr(0, ins(1, 0)); wr(1, ins(5, 6)); wr(2, ins(7, 0)); wr(6, ins(7, 0));
        R = 0;
        tick(1);
        chk("t3_pc1", int'(PC_out), 1);
        tick(1);
        chk("t3_jz_taken", int'(PC_out), 6);
        tick(1);

        // JZ not taken
        R = 1;
        wr(0, ins(1, 1));
        R = 0;
        tick(2);
        chk("t3_jz_not", int'(PC_out), 2);
        tick(1);

        // Wrap: JMP 255, mem[255]=NOP
        R = 1;
        wr(0, ins(4, 255)); wr(255, ins(0, 0));
        R = 0;
        tick(1);
        chk("t4_pc255", int'(PC_out), 255);
        chk("t4_adder0", int'(adder_out), 0);
        tick(1);
        chk("t4_wrap", int'(PC_out), 0);
        tick(1);

        // Async reset mid-run at PC=5 with Output=7; run ignored while running
        R = 1;
        wr(0, ins(1, 7)); wr(1, ins(3, 0)); wr(2, 0); wr(3, 0); wr(4, 0); wr(5, 0);
        R = 0;
        tick(2);
        run = 1;
        tick(3);
        run = 0;
        chk("t5_pc5", int'(PC_out), 5);
        chk("t5_out7", int'(Output), 7);
        #2;
        R = 1;
        #1;
        chk("t5_async_pc", int'(PC_out), 0);
        chk("t5_async_out", int'(Output), 0);
        chk("t5_async_halted", int'(halted), 0);
        tick(1);

        // Write to the executing address: old word runs, new word kept
        wr(0, ins(0, 0)); wr(1, ins(1, 9)); wr(2, ins(3, 0)); wr(3, ins(7, 0));
        prog_we = 1; prog_addr = 0; prog_data = ins(7, 0);
        R = 0;
        tick(1);
        prog_we = 0;
        chk("t6_old_word", int'(PC_out), 1);
        tick(2);
        chk("t6_output", int'(Output), 9);
        R = 1;
        #1;
        chk("t6_new_word", int'(memory_out), int'(ins(7, 0)));
        tick(1);

        // Single-step program: LDI 2; ADDI 1; OUT; HALT
        wr(0, ins(1, 2)); wr(1, ins(2, 1)); wr(2, ins(3, 0)); wr(3, ins(7, 0));
        step = 0;
        R = 0;
        tick(3);
`ifdef CIPS_SINGLE_STEP_EN
        chk("ss_idle_pc", int'(PC_out), 0);
        chk("ss_idle_out", int'(Output), 0);
        step = 1;
        tick(1);
        step = 0;
        chk("ss_step_pc", int'(PC_out), 1);
        tick(3);
        chk("ss_hold_pc", int'(PC_out), 1);
        step = 1;
        tick(2);
        chk("ss_pc3", int'(PC_out), 3);
        chk("ss_out", int'(Output), 3);
        chk("ss_valid", int'(out_valid), 1);
`else
        chk("nostep_pc", int'(PC_out), 3);
        chk("nostep_out", int'(Output), 3);
`endif
        step = 1;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cips_seq.md
# cips_seq

Parametrised successor of the CIPS processor: a single-cycle microsequencer with a program counter, a writable program memory, a PC incrementer, an accumulator with carry, and a registered output port. It adds conditional and unconditional jumps, a halt/resume mechanism and a run-time program-load port. It sits at the top of the CIPS datapath. It keeps the CIPS debug outputs (PC, fetched word, adder, output) so the same waveform views apply.

## Interface
- PC_W, 8, program counter width; program memory depth = 2^PC_W.
- DATA_W, 5, accumulator/output width; must be <= PC_W.
- INSTR_W (localparam) = PC_W+3; instruction layout is opcode [INSTR_W-1:PC_W] and operand [PC_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- R  in  1  asynchronous, active-high reset.
- prog_we  in  1  program memory write enable.
- prog_addr  in  PC_W  write address.
- prog_data  in  INSTR_W  write data.
- run  in  1  resumes execution from HALT.
- step  in  1  single-step strobe; used only with CIPS_SINGLE_STEP_EN, otherwise ignored.
- PC_out  out  PC_W  current PC register.
- memory_out  out  INSTR_W  mem[PC], combinational read.
- adder_out  out  PC_W  PC+1, mod 2^PC_W.
- Output  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse on the cycle after an OUT executes.
- halted  out  1  high while in the HALT state.

## Operation
- States: RUN and HALT. Reset enters RUN.
- In RUN, one instruction executes per clock edge. The instruction is memory_out at that edge.
- Opcodes (ACC = accumulator, C = carry flag, K = operand[DATA_W-1:0]):
  - 000 NOP: PC <= PC+1.
  - 001 LDI: ACC <= K; C <= 0.
  - 010 ADDI: {C,ACC} <= ACC+K, computed at DATA_W+1 bits.
  - 011 OUT: Output <= ACC; out_valid <= 1.
  - 100 JMP: PC <= operand.
  - 101 JZ: PC <= operand if ACC==0, else PC+1.
  - 110 JC: PC <= operand if C==1, else PC+1.
  - 111 HALT: PC holds; state <= HALT.
- Every opcode not listed as setting PC advances PC by PC+1.
- In HALT:
  - PC, ACC, C and Output hold.
  - run=1 at an edge: PC <= PC+1, state <= RUN.
- out_valid is 0 on every cycle not immediately following an OUT.

## Timing
- Reset values: PC_out=0, Output=0, out_valid=0, halted=0, ACC=0, C=0, state RUN.
- memory_out and adder_out track PC_out combinationally. Reset does not clear memory contents.
- Asserting R mid-run takes effect immediately, with no clock needed.
- The first instruction, mem[0], executes on the first edge after R falls.
- Latency:
  - Register effects of an instruction are visible after the edge that executes it.
  - Output and out_valid update on that same edge.
- Program writes:
  - A write occurs at the edge where prog_we=1, including while running.
  - If prog_addr==PC at that edge, the old word executes and the new word is visible afterwards.
- Wrap-around: PC+1 from 2^PC_W-1 gives 0. ADDI overflow wraps ACC and sets C.
- The HALT edge sets halted=1 on the following cycle. The run edge clears halted.
- run=1 while in RUN is ignored.

## Configuration
- CIPS_SINGLE_STEP_EN defined:
  - In RUN, an instruction executes only at edges where step=1.
  - At other edges all state holds and out_valid=0.
  - HALT/run behaviour is unchanged.
- CIPS_SINGLE_STEP_EN undefined: step is ignored; the block executes every edge.

## Test plan
- Program via the load port while R=1: LDI 3; ADDI 4; OUT; HALT. Release R.
  - Expected: Output=7 with out_valid high for exactly one cycle; halted=1 with PC_out=3 holding.
  - Then pulse run: PC_out becomes 4.
- Carry: LDI 30; ADDI 5; JC 10; mem[10]=OUT.
  - Expected: ACC=3 and C=1; PC goes 2->10; Output=3.
- JZ taken and not taken:
  - LDI 0; JZ 6 -> PC 1->6.
  - LDI 1; JZ 6 -> PC 1->2.
- Wrap: mem[0]=JMP 255, mem[255]=NOP.
  - Expected: PC sequence 0, 255, 0, with adder_out=0 while PC=255.
- Async reset between edges while executing at PC=5 with Output=7.
  - Expected: PC_out=0 and Output=0 immediately; halted=0.
- With CIPS_SINGLE_STEP_EN, running a 4-instruction program:
  - PC advances only on edges with step=1.
  - 3 idle cycles leave PC and Output unchanged.
